// File: rtl/x72_pkg.sv
// rtl/x72_pkg.sv - shared constants and types for the x72 control path
// Purpose: opcode, bus-select, ALU-op and tick-phase constants used by the
//          control unit and the tick FSM, plus the sequencer state type.
// Ports:   none (package).
package x72_pkg;

  localparam logic [3:0] OP_MV  = 4'b0000;
  localparam logic [3:0] OP_MVI = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_SH  = 4'b0101;

  localparam logic [3:0] SEL_G   = 4'b1000;
  localparam logic [3:0] SEL_DIN = 4'b1001;

  localparam logic [2:0] ALU_MUL   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_SHIFT = 3'b011;

  localparam logic [3:0] TICK1 = 4'b0001;
  localparam logic [3:0] TICK2 = 4'b0010;
  localparam logic [3:0] TICK3 = 4'b0100;
  localparam logic [3:0] TICK4 = 4'b1000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // Three-phase instructions: go through A and G before writing back.
  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_SH);
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    logic [2:0] r;
    case (op)
      OP_ADD:  r = ALU_ADD;
      OP_SUB:  r = ALU_SUB;
      OP_SH:   r = ALU_SHIFT;
      default: r = ALU_MUL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// rtl/dec3to8.sv - 3-to-8 one-hot decoder with enable
// Purpose: turns a register index into a one-hot load strobe.
// Ports:   i_sel register index, i_en write strobe, o_y one-hot output
//          (all zero when i_en is low).
module dec3to8 (
  input  logic [2:0] i_sel,
  input  logic       i_en,
  output logic [7:0] o_y
);

  assign o_y = i_en ? (8'b0000_0001 << i_sel) : 8'b0000_0000;

endmodule

// File: rtl/register_n.sv
// rtl/register_n.sv - N-bit load-enabled register
// Purpose: general-purpose register with synchronous active-high clear.
// Ports:   clk, rst (sync, active-high), i_en load enable, i_d data in,
//          o_q registered value.
module register_n #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - x72 instruction sequencer
// Purpose: captures an instruction on run, steps it through the tick phases
//          and decodes tick + opcode into datapath controls.
// Ports:   clk, rst (sync, active-high); run start request; din instruction;
//          tick one-hot phase in; tick_en/tick_clr to the tick FSM;
//          imm IR[8:0]; sel bus select; r_in one-hot R0-R7 load;
//          a_in/g_in A/G load; alu_op ALU function; done retire pulse;
//          busy high in EXEC.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] din,
  input  logic [3:0]  tick,
  output logic        tick_en,
  output logic        tick_clr,
  output logic [8:0]  imm,
  output logic [3:0]  sel,
  output logic [7:0]  r_in,
  output logic        a_in,
  output logic        g_in,
  output logic [2:0]  alu_op,
  output logic        done,
  output logic        busy
);

  import x72_pkg::*;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_load;
  logic        w_wr;
  logic [15:0] w_ir;
  logic [3:0]  w_op;
  logic [2:0]  w_rx;
  logic [2:0]  w_ry;

  register_n #(.N(16)) u_ir (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_load),
    .i_d  (din),
    .o_q  (w_ir)
  );

  dec3to8 u_rdec (
    .i_sel (w_rx),
    .i_en  (w_wr),
    .o_y   (r_in)
  );

  assign w_op = w_ir[15:12];
  assign w_rx = w_ir[11:9];
  assign w_ry = w_ir[2:0];
  assign imm  = w_ir[8:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_wr         = 1'b0;
    tick_en      = 1'b0;
    tick_clr     = 1'b0;
    sel          = 4'b0000;
    a_in         = 1'b0;
    g_in         = 1'b0;
    alu_op       = 3'b000;
    done         = 1'b0;
    busy         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_load       = 1'b1;
          tick_en      = 1'b1;
          w_state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        busy    = 1'b1;
        tick_en = 1'b1;
        case (tick)
          TICK2: begin
            if (is_alu(w_op)) begin
              sel  = {1'b0, w_rx};
              a_in = 1'b1;
            end else begin
              // mv, mvi and every undefined opcode retire here.
              done     = 1'b1;
              tick_clr = 1'b1;
              if (w_op == OP_MV) begin
                sel  = {1'b0, w_ry};
                w_wr = 1'b1;
              end else if (w_op == OP_MVI) begin
                sel  = SEL_DIN;
                w_wr = 1'b1;
              end
            end
          end
          TICK3: begin
            if (is_alu(w_op)) begin
              sel    = {1'b0, w_ry};
              g_in   = 1'b1;
              alu_op = alu_op_of(w_op);
            end else begin
              tick_clr     = 1'b1;
              w_state_next = ST_IDLE;
            end
          end
          TICK4: begin
            if (is_alu(w_op)) begin
              sel      = SEL_G;
              w_wr     = 1'b1;
              done     = 1'b1;
              tick_clr = 1'b1;
            end else begin
              tick_clr     = 1'b1;
              w_state_next = ST_IDLE;
            end
          end
          // T1 or a non-one-hot phase means the tick FSM lost sync with us:
          // drop the instruction and resynchronise both sides.
          default: begin
            tick_clr     = 1'b1;
            w_state_next = ST_IDLE;
          end
        endcase
        if (done) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard testbench for control_unit
module tb_control_unit;

  typedef struct packed {
    logic       tick_en;
    logic       tick_clr;
    logic [8:0] imm;
    logic [3:0] sel;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic [2:0] alu_op;
    logic       done;
    logic       busy;
  } ctl_t;

  typedef struct {
    ctl_t  v;
    string tag;
  } exp_item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  tick;
  logic        tick_en, tick_clr, a_in, g_in, done, busy;
  logic [8:0]  imm;
  logic [3:0]  sel;
  logic [7:0]  r_in;
  logic [2:0]  alu_op;

  logic [3:0]  env_tick = 4'b0001;
  logic        force_en = 1'b0;
  logic [3:0]  force_val = 4'b0000;

  exp_item_t   exp_q[$];
  logic [15:0] m_ir = '0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  assign tick = force_en ? force_val : env_tick;

  // Tick FSM environment: clear/reset to T1, otherwise rotate when enabled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || tick_clr) env_tick <= 4'b0001;
    else if (tick_en)    env_tick <= {env_tick[2:0], env_tick[3]};
  end

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .din      (din),
    .tick     (tick),
    .tick_en  (tick_en),
    .tick_clr (tick_clr),
    .imm      (imm),
    .sel      (sel),
    .r_in     (r_in),
    .a_in     (a_in),
    .g_in     (g_in),
    .alu_op   (alu_op),
    .done     (done),
    .busy     (busy)
  );

  // Monitor: one expected control vector per driven cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_item_t it;
      ctl_t      act;
      it  = exp_q.pop_front();
      act = '{tick_en, tick_clr, imm, sel, r_in, a_in, g_in, alu_op, done, busy};
      n_checks++;
      if (act !== it.v) begin
        n_errors++;
        $display("FAIL %s cyc=%0d got=%h required=%h (te,tc,imm,sel,r_in,a,g,alu,done,busy)",
                 it.tag, cyc, act, it.v);
      end
    end
  end

  function automatic ctl_t exp_idle(input logic runv, input logic [15:0] ir);
    ctl_t e = '0;
    e.tick_en = runv;
    e.imm     = ir[8:0];
    return e;
  endfunction

  function automatic bit op_is_alu(input logic [15:0] ir);
    return (ir[15:12] >= 4'd2) && (ir[15:12] <= 4'd5);
  endfunction

  // Reference: the micro-steps an instruction takes, straight from the opcode table.
  function automatic ctl_t exp_exec(input logic [15:0] ir, input int step);
    ctl_t       e = '0;
    logic [3:0] op = ir[15:12];
    logic [2:0] rx = ir[11:9];
    logic [2:0] ry = ir[2:0];
    e.tick_en = 1'b1;
    e.busy    = 1'b1;
    e.imm     = ir[8:0];
    if (!op_is_alu(ir)) begin
      e.done     = 1'b1;
      e.tick_clr = 1'b1;
      if (op == 4'd0) begin
        e.sel  = {1'b0, ry};
        e.r_in = 8'b1 << rx;
      end else if (op == 4'd1) begin
        e.sel  = 4'd9;
        e.r_in = 8'b1 << rx;
      end
    end else if (step == 0) begin
      e.sel  = {1'b0, rx};
      e.a_in = 1'b1;
    end else if (step == 1) begin
      e.sel    = {1'b0, ry};
      e.g_in   = 1'b1;
      e.alu_op = (op == 4'd2) ? 3'd1 : (op == 4'd3) ? 3'd2 : (op == 4'd4) ? 3'd0 : 3'd3;
    end else begin
      e.sel      = 4'd8;
      e.r_in     = 8'b1 << rx;
      e.done     = 1'b1;
      e.tick_clr = 1'b1;
    end
    return e;
  endfunction

  function automatic ctl_t exp_abort(input logic [15:0] ir);
    ctl_t e = '0;
    e.tick_en  = 1'b1;
    e.tick_clr = 1'b1;
    e.busy     = 1'b1;
    e.imm      = ir[8:0];
    return e;
  endfunction

  task automatic push(input ctl_t v, input string tag);
    exp_item_t it;
    it.v   = v;
    it.tag = tag;
    exp_q.push_back(it);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    force_en = 1'b0;
  endtask

  task automatic idle_cycle();
    next_cycle();
    run = 1'b0;
    din = 16'($urandom);
    push(exp_idle(1'b0, m_ir), "idle");
  endtask

  // abort_kind: 0 none, 1 reset, 2 tick forced 0000, 3 tick forced T1.
  task automatic do_instr(input logic [15:0] ir, input bit hold, input int abort_step,
                          input int abort_kind);
    int n;
    next_cycle();
    run = 1'b1;
    din = ir;
    push(exp_idle(1'b1, m_ir), "accept");
    m_ir = ir;
    n = op_is_alu(ir) ? 3 : 1;
    for (int s = 0; s < n; s++) begin
      next_cycle();
      run = hold ? 1'b1 : 1'($urandom_range(0, 1));
      din = 16'($urandom);
      if (abort_kind != 0 && s == abort_step) begin
        if (abort_kind == 1) begin
          rst = 1'b1;
          push(exp_exec(ir, s), "rst_cycle");
          m_ir = '0;
        end else begin
          force_en  = 1'b1;
          force_val = (abort_kind == 2) ? 4'b0000 : 4'b0001;
          push(exp_abort(ir), (abort_kind == 2) ? "tick_zero" : "tick_t1");
        end
        break;
      end
      push(exp_exec(ir, s), "exec");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ir;
    int          kind;
    int          step;
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk);
    #1;
    // Reset state.
    idle_cycle();
    // mvi R3 <- 0FF, then busy drops.
    do_instr(16'h16FF, 1'b0, -1, 0);
    idle_cycle();
    // add R1, R2 phase sequence.
    do_instr({4'h2, 3'd1, 6'd0, 3'd2}, 1'b0, -1, 0);
    idle_cycle();
    // sub with run held high: back-to-back accepts one cycle after done.
    do_instr({4'h3, 3'd5, 6'd0, 3'd6}, 1'b1, -1, 0);
    do_instr({4'h3, 3'd5, 6'd0, 3'd6}, 1'b1, -1, 0);
    do_instr({4'h3, 3'd5, 6'd0, 3'd6}, 1'b1, -1, 0);
    idle_cycle();
    // rst during T3 of mul, then a normal mv.
    do_instr({4'h4, 3'd2, 6'd0, 3'd4}, 1'b0, 1, 1);
    idle_cycle();
    do_instr({4'h0, 3'd7, 6'd0, 3'd3}, 1'b0, -1, 0);
    idle_cycle();
    // Undefined opcode retires as NOP.
    do_instr(16'hF123, 1'b0, -1, 0);
    idle_cycle();
    // Forced tick 0000 in EXEC, at T2 and at T3.
    do_instr({4'h2, 3'd0, 6'd0, 3'd1}, 1'b0, 0, 2);
    idle_cycle();
    do_instr({4'h5, 3'd6, 6'd0, 3'd7}, 1'b0, 1, 2);
    idle_cycle();
    // Tick stuck at T1 in EXEC.
    do_instr({4'h1, 3'd4, 9'h1AB}, 1'b0, 0, 3);
    idle_cycle();
    do_instr({4'h1, 3'd4, 9'h155}, 1'b0, -1, 0);
    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      ir   = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ir[15:12] = 4'($urandom_range(0, 5));
      kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      step = op_is_alu(ir) ? int'($urandom_range(0, 2)) : 0;
      do_instr(ir, 1'($urandom_range(0, 1)), step, kind);
      if (kind == 1) idle_cycle();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
    end
    idle_cycle();
    next_cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain got=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
